// File: rtl/jump_ctrl_pkg.sv
// Shared definitions for the jump controller.
//   - FSM state encoding (FETCH -> WAIT -> DECODE)
//   - opcode constants for the flow-control instructions
//   - opcode_of(): extracts the opcode nibble from an instruction byte
package jump_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DECODE = 2'd2
  } state_e;

  localparam logic [3:0] OP_JMP  = 4'hF;
  localparam logic [3:0] OP_JZ   = 4'hE;
  localparam logic [3:0] OP_JNZ  = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hB;

  function automatic logic [3:0] opcode_of(input logic [7:0] byte_in);
    return byte_in[7:4];
  endfunction

endpackage

// File: rtl/jump_ctrl_stack.sv
// Return-address LIFO for CALL/RET.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (empties the stack)
//   push, pop     push_data is stored on push; the top entry is dropped on pop
//   push_data     return address to store
//   full, empty   occupancy flags; push when full / pop when empty is ignored
//   top_data      most recently pushed entry (meaningless while empty)
module jump_ctrl_stack #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [IDX_W-1:0] wr_idx, top_idx;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_idx   = IDX_W'(count_q);
  assign top_idx  = IDX_W'(count_q - 1'b1);
  assign top_data = mem_q[top_idx];

  // NOTE: every variable gets a default before any condition so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (push && !full)       count_d = count_q + 1'b1;
    else if (pop && !empty)  count_d = count_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // NOTE: storage is not reset; clearing the count empties the stack and
  // entries above the count are never read.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/jump_controller.sv
// Jump controller: fetches one instruction byte every three cycles and either
// pulses jump (with a target on custom_data) or pc_step to the program counter.
// Non-flow instructions are forwarded on instr/instr_valid.
// Optional feature macro: JUMP_CTRL_STACK_EN enables CALL/RET with a
// return-address stack and the sticky stack_err flag; without it CALL/RET are
// ordinary non-flow opcodes and stack_err is tied 0.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   run                 allows a new fetch; in-flight instructions always complete
//   pc                  current program counter
//   mem_rd, mem_addr    program memory read strobe/address (FETCH cycle only)
//   mem_data            instruction byte, valid the cycle after mem_rd
//   zero_flag           ALU zero flag for JZ/JNZ
//   jump, custom_data   PC load pulse and target (target holds between pulses)
//   pc_step             PC advance pulse
//   instr, instr_valid  non-flow instruction and its one-cycle qualifier
//   stack_err           sticky stack overflow/underflow
module jump_controller
  import jump_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              zero_flag,
  output logic              jump,
  output logic [ADDR_W-1:0] custom_data,
  output logic              pc_step,
  output logic [7:0]        instr,
  output logic              instr_valid,
  output logic              stack_err
);

  state_e            state_q, state_d;
  logic              armed_q;
  logic              jump_q, jump_d;
  logic              pc_step_q, pc_step_d;
  logic              instr_valid_q, instr_valid_d;
  logic [7:0]        instr_q, instr_d;
  logic [ADDR_W-1:0] custom_data_q, custom_data_d;
  logic [ADDR_W-1:0] operand;

  assign operand = ADDR_W'(mem_data[3:0]);

`ifdef JUMP_CTRL_STACK_EN
  logic              stack_err_q, stack_err_d;
  logic              push, pop, stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top, ret_addr;

  assign ret_addr = pc + ADDR_W'(1);

  jump_ctrl_stack #(.W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .full      (stk_full),
    .empty     (stk_empty),
    .top_data  (stk_top)
  );
`endif

  // The pulse outputs are registered, so the decision is made from mem_data
  // during WAIT and the pulse is visible throughout the DECODE cycle.
  always_comb begin
    state_d       = state_q;
    mem_rd        = 1'b0;
    jump_d        = 1'b0;
    pc_step_d     = 1'b0;
    instr_valid_d = 1'b0;
    instr_d       = instr_q;
    custom_data_d = custom_data_q;
`ifdef JUMP_CTRL_STACK_EN
    stack_err_d   = stack_err_q;
    push          = 1'b0;
    pop           = 1'b0;
`endif
    case (state_q)
      ST_FETCH: begin
        // armed_q keeps mem_rd low while reset is asserted and for the first
        // edge after release.
        if (armed_q && run) begin
          mem_rd  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d = ST_DECODE;
        instr_d = mem_data;
        case (opcode_of(mem_data))
          OP_JMP: begin
            jump_d        = 1'b1;
            custom_data_d = operand;
          end
          OP_JZ, OP_JNZ: begin
            if (zero_flag == (opcode_of(mem_data) == OP_JZ)) begin
              jump_d        = 1'b1;
              custom_data_d = operand;
            end else begin
              pc_step_d = 1'b1;
            end
          end
`ifdef JUMP_CTRL_STACK_EN
          OP_CALL: begin
            if (!stk_full) begin
              push          = 1'b1;
              jump_d        = 1'b1;
              custom_data_d = operand;
            end else begin
              pc_step_d   = 1'b1;
              stack_err_d = 1'b1;
            end
          end
          OP_RET: begin
            if (!stk_empty) begin
              pop           = 1'b1;
              jump_d        = 1'b1;
              custom_data_d = stk_top;
            end else begin
              pc_step_d   = 1'b1;
              stack_err_d = 1'b1;
            end
          end
`endif
          default: begin
            pc_step_d     = 1'b1;
            instr_valid_d = 1'b1;
          end
        endcase
      end
      ST_DECODE: state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  assign mem_addr = mem_rd ? pc : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      armed_q       <= 1'b0;
      jump_q        <= 1'b0;
      pc_step_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      custom_data_q <= '0;
    end else begin
      state_q       <= state_d;
      armed_q       <= 1'b1;
      jump_q        <= jump_d;
      pc_step_q     <= pc_step_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      custom_data_q <= custom_data_d;
    end
  end

`ifdef JUMP_CTRL_STACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stack_err_q <= 1'b0;
    else        stack_err_q <= stack_err_d;
  end
  assign stack_err = stack_err_q;
`else
  assign stack_err = 1'b0;
`endif

  assign jump        = jump_q;
  assign pc_step     = pc_step_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign custom_data = custom_data_q;

endmodule

// File: tb/tb_jump_controller.sv
// Self-checking bench for jump_controller. Inputs change on the falling edge;
// outputs are sampled 1 time unit before the next rising edge. An
// instruction-level model (queue stack, per-opcode rules) supplies the expected
// pulse, target and error flag; literal checks pin the model on known cases.
module tb_jump_controller;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk, rst_n, run, zero_flag;
  logic [ADDR_W-1:0] pc, mem_addr, custom_data;
  logic [7:0]        mem_data, instr;
  logic              mem_rd, jump, pc_step, instr_valid, stack_err;

  int checks = 0;
  int fails  = 0;

  // model state
  logic [ADDR_W-1:0] m_custom;
  logic              m_err;
  logic [ADDR_W-1:0] m_stack[$];

  // DUT values seen in the most recent DECODE cycle
  logic       last_jump, last_step, last_valid;
  logic [7:0] last_instr;

  jump_controller #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .pc          (pc),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .zero_flag   (zero_flag),
    .jump        (jump),
    .custom_data (custom_data),
    .pc_step     (pc_step),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stack_err   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_custom = '0;
    m_err    = 1'b0;
    m_stack.delete();
  endtask

  // Instruction-level behaviour: what the decode cycle must show for this byte.
  task automatic predict(input logic [ADDR_W-1:0] p, input logic [7:0] d, input logic zf,
                         output logic ej, output logic es, output logic ev);
    logic [3:0] op;
    logic [ADDR_W-1:0] tgt;
    op  = d[7:4];
    tgt = ADDR_W'(d[3:0]);
    ej = 1'b0; es = 1'b0; ev = 1'b0;
    if (op == 4'hF || (op == 4'hE && zf) || (op == 4'hD && !zf)) begin
      ej = 1'b1; m_custom = tgt;
    end else if (op == 4'hE || op == 4'hD) begin
      es = 1'b1;
    end
`ifdef JUMP_CTRL_STACK_EN
    else if (op == 4'hC) begin
      if (m_stack.size() < DEPTH) begin
        m_stack.push_back(p + ADDR_W'(1));
        ej = 1'b1; m_custom = tgt;
      end else begin
        es = 1'b1; m_err = 1'b1;
      end
    end else if (op == 4'hB) begin
      if (m_stack.size() > 0) begin
        m_custom = m_stack.pop_back();
        ej = 1'b1;
      end else begin
        es = 1'b1; m_err = 1'b1;
      end
    end
`endif
    else begin
      es = 1'b1; ev = 1'b1;
    end
  endtask

  task automatic check_quiet(input string tag, input logic exp_rd, input logic [ADDR_W-1:0] exp_addr);
    check({tag, " mem_rd"},      mem_rd, exp_rd);
    check({tag, " mem_addr"},    mem_addr, exp_addr);
    check({tag, " jump"},        jump, 1'b0);
    check({tag, " pc_step"},     pc_step, 1'b0);
    check({tag, " instr_valid"}, instr_valid, 1'b0);
    check({tag, " custom_data"}, custom_data, m_custom);
    check({tag, " stack_err"},   stack_err, m_err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_rd"},      mem_rd, 1'b0);
    check({tag, " mem_addr"},    mem_addr, '0);
    check({tag, " jump"},        jump, 1'b0);
    check({tag, " pc_step"},     pc_step, 1'b0);
    check({tag, " instr_valid"}, instr_valid, 1'b0);
    check({tag, " instr"},       instr, 8'h00);
    check({tag, " custom_data"}, custom_data, '0);
    check({tag, " stack_err"},   stack_err, 1'b0);
  endtask

  // Runs one full FETCH/WAIT/DECODE instruction; starts and ends just after a falling edge.
  task automatic do_instr(input logic [ADDR_W-1:0] p, input logic [7:0] d, input logic zf,
                          input logic drop_run);
    logic ej, es, ev;
    run = 1'b1; pc = p; zero_flag = zf; mem_data = 8'h00;
    #4; check_quiet("fetch", 1'b1, p);
    @(negedge clk);
    mem_data = d;
    if (drop_run) run = 1'b0;
    #4; check_quiet("wait", 1'b0, '0);
    @(negedge clk);
    mem_data = 8'h00;
    predict(p, d, zf, ej, es, ev);
    #4;
    check("decode jump",        jump, ej);
    check("decode pc_step",     pc_step, es);
    check("decode instr_valid", instr_valid, ev);
    check("decode mem_rd",      mem_rd, 1'b0);
    check("decode custom_data", custom_data, m_custom);
    check("decode stack_err",   stack_err, m_err);
    if (ev) check("decode instr", instr, d);
    last_jump = jump; last_step = pc_step; last_valid = instr_valid; last_instr = instr;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; pc = '0; mem_data = 8'h00; zero_flag = 1'b0;
    model_reset();
    @(negedge clk);
    run = 1'b1; pc = 4'h7;
    #4; check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0;
    // run low: controller must stay idle in FETCH
    for (int i = 0; i < 3; i++) begin
      #4; check_quiet("idle", 1'b0, '0);
      @(negedge clk);
    end

    // JMP 9
    do_instr(4'h3, 8'hF9, 1'b0, 1'b0);
    check("lit jmp jump", last_jump, 1'b1);
    check("lit jmp pc_step", last_step, 1'b0);
    check("lit jmp target", custom_data, 4'h9);
    // JZ untaken, then taken
    do_instr(4'h3, 8'hE5, 1'b0, 1'b0);
    check("lit jz0 pc_step", last_step, 1'b1);
    check("lit jz0 jump", last_jump, 1'b0);
    check("lit jz0 hold", custom_data, 4'h9);
    do_instr(4'h3, 8'hE5, 1'b1, 1'b0);
    check("lit jz1 jump", last_jump, 1'b1);
    check("lit jz1 target", custom_data, 4'h5);
    // JNZ both ways
    do_instr(4'h4, 8'hD7, 1'b1, 1'b0);
    do_instr(4'h4, 8'hD7, 1'b0, 1'b0);
    check("lit jnz0 target", custom_data, 4'h7);
    // non-flow
    do_instr(4'h6, 8'h27, 1'b0, 1'b0);
    check("lit nonflow instr", last_instr, 8'h27);
    check("lit nonflow valid", last_valid, 1'b1);
    check("lit nonflow step", last_step, 1'b1);
    // run dropped mid-instruction must not abort it
    do_instr(4'h7, 8'h3A, 1'b0, 1'b1);
    do_instr(4'h8, 8'hFC, 1'b0, 1'b1);
    check("lit droprun target", custom_data, 4'hC);

`ifdef JUMP_CTRL_STACK_EN
    do_instr(4'hF, 8'hC2, 1'b0, 1'b0);
    check("lit call target", custom_data, 4'h2);
    do_instr(4'h2, 8'hB0, 1'b0, 1'b0);
    check("lit ret jump", last_jump, 1'b1);
    check("lit ret wrap", custom_data, 4'h0);
    for (int i = 1; i <= 5; i++) do_instr(ADDR_W'(i), 8'hC0 | 8'(i), 1'b0, 1'b0);
    check("lit overflow step", last_step, 1'b1);
    check("lit overflow jump", last_jump, 1'b0);
    check("lit overflow err", stack_err, 1'b1);
    for (int i = 0; i < 4; i++) do_instr(4'h9, 8'hB0, 1'b0, 1'b0);
    check("lit last pop", custom_data, 4'h2);
    do_instr(4'h9, 8'hB0, 1'b0, 1'b0);
    check("lit underflow step", last_step, 1'b1);
    check("lit underflow err", stack_err, 1'b1);
`else
    do_instr(4'hF, 8'hC2, 1'b0, 1'b0);
    check("lit call nonflow", last_valid, 1'b1);
    do_instr(4'h2, 8'hB0, 1'b0, 1'b0);
    check("lit ret nonflow", last_step, 1'b1);
    check("lit no stack_err", stack_err, 1'b0);
`endif

    // reset asserted during WAIT discards the instruction
    run = 1'b1; pc = 4'h5; mem_data = 8'h00;
    #4; check_quiet("prerst fetch", 1'b1, 4'h5);
    @(negedge clk);
    mem_data = 8'hF1;
    #1; rst_n = 1'b0; model_reset();
    #3; check_all_zero("rst in wait");
    @(negedge clk);
    mem_data = 8'h00;
    #4; check_all_zero("rst held");
    @(negedge clk);
    rst_n = 1'b1;
    #4; check_all_zero("rst release");
    @(negedge clk);
    // first fetch comes one cycle after release
    do_instr(4'h5, 8'h27, 1'b0, 1'b0);
    check("lit post-reset target", custom_data, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
